pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl.sv | 111 +++++++++++
 tb/tb_pc_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// Program-counter sequencer with stall, redirect, and a circular return-address stack.
// All state advances on the falling clock edge. An active-high reset clears the state asynchronously.
module pc_ctrl #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned STEP      = 4,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             hd_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] target_i,
  input  logic             call_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_seq_o,
  output logic             valid_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic             ras_err_o
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [WIDTH-1:0] ResetPc = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] Step    = WIDTH'(STEP);
  localparam logic [CntW-1:0]  CntFull = CntW'(RAS_DEPTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  pc_q;
  logic              valid_q;
  logic              err_q;
  logic [CntW-1:0]   cnt_q;
  logic [PtrW-1:0]   top_q;
  logic [WIDTH-1:0]  ras_mem [RAS_DEPTH];

  logic              run;
  logic              do_push;
  logic [PtrW-1:0]   push_idx;
  logic [WIDTH-1:0]  pc_seq;

  always_comb begin
    run      = (state_q == StRun);
    do_push  = run && !hd_i && redirect_i && call_i;
    push_idx = top_q + PtrW'(1);
    pc_seq   = pc_q + Step;
  end

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pc_q    <= ResetPc;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      top_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StRun;
            pc_q    <= ResetPc;
            valid_q <= 1'b1;
          end
        end
        StRun: begin
          if (!hd_i) begin
            if (redirect_i) begin
              pc_q <= target_i;
              if (call_i) begin
                // When the stack is full, the push lands on the oldest slot.
                top_q <= push_idx;
                if (cnt_q != CntFull) cnt_q <= cnt_q + CntW'(1);
                else err_q <= 1'b1;
              end
            end else if (ret_i) begin
              if (cnt_q != '0) begin
                pc_q  <= ras_mem[top_q];
                top_q <= top_q - PtrW'(1);
                cnt_q <= cnt_q - CntW'(1);
              end else begin
                pc_q  <= pc_seq;
                err_q <= 1'b1;
              end
            end else begin
              pc_q <= pc_seq;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Entry storage needs no reset; only the count and pointer define validity.
  always_ff @(negedge clk_i) begin
    if (do_push) ras_mem[push_idx] <= pc_seq;
  end

  assign pc_o        = pc_q;
  assign pc_seq_o    = pc_seq;
  assign valid_o     = valid_q;
  assign ras_empty_o = (cnt_q == '0);
  assign ras_full_o  = (cnt_q == CntFull);
  assign ras_err_o   = err_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed, table-driven bench for pc_ctrl. It uses a 32-bit default instance and an 8-bit instance for the wrap check.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, hd, redir, call, ret;
  logic [31:0] target;
  logic [31:0] pc, pc_seq;
  logic        valid, empty, full, err;

  logic        start8, redir8;
  logic [7:0]  target8, pc8, pc_seq8;
  logic        valid8, empty8, full8, err8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .hd_i(hd), .redirect_i(redir),
    .target_i(target), .call_i(call), .ret_i(ret), .pc_o(pc), .pc_seq_o(pc_seq),
    .valid_o(valid), .ras_empty_o(empty), .ras_full_o(full), .ras_err_o(err)
  );

  pc_ctrl #(.WIDTH(8), .STEP(4)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .hd_i(1'b0), .redirect_i(redir8),
    .target_i(target8), .call_i(1'b0), .ret_i(1'b0), .pc_o(pc8), .pc_seq_o(pc_seq8),
    .valid_o(valid8), .ras_empty_o(empty8), .ras_full_o(full8), .ras_err_o(err8)
  );

  typedef struct {
    logic        start, hd, redir, call, ret;
    logic [31:0] target;
    logic [31:0] pc;
    logic        valid, empty, full, err;
  } vec_t;

  localparam int NVec = 26;
  vec_t tbl [NVec];

  function automatic vec_t mk(input logic s, input logic h, input logic r, input logic c,
                              input logic rt, input logic [31:0] t, input logic [31:0] p,
                              input logic v, input logic e, input logic f, input logic er);
    vec_t x;
    x.start = s; x.hd = h; x.redir = r; x.call = c; x.ret = rt; x.target = t;
    x.pc = p; x.valid = v; x.empty = e; x.full = f; x.err = er;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 2 time units after the active (falling) edge.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic check_all(input string tag, input logic [31:0] p, input logic v,
                           input logic e, input logic f, input logic er);
    check({tag, " pc"}, pc, p);
    check({tag, " pc_seq"}, pc_seq, p + 32'd4);
    check({tag, " valid"}, 32'(valid), 32'(v));
    check({tag, " empty"}, 32'(empty), 32'(e));
    check({tag, " full"}, 32'(full), 32'(f));
    check({tag, " err"}, 32'(err), 32'(er));
  endtask

  initial begin
    //              st hd rd ca rt target        pc            v  e  f  err
    tbl[0]  = mk(1, 0, 0, 0, 0, 32'h0,   32'h0,   1, 1, 0, 0); // start
    tbl[1]  = mk(0, 0, 0, 0, 0, 32'h0,   32'h4,   1, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 32'h0,   32'h8,   1, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 32'h0,   32'hC,   1, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 32'h0,   32'h10,  1, 1, 0, 0);
    tbl[5]  = mk(0, 1, 1, 0, 0, 32'h80,  32'h10,  1, 1, 0, 0); // stall beats redirect
    tbl[6]  = mk(0, 1, 1, 0, 0, 32'h80,  32'h10,  1, 1, 0, 0);
    tbl[7]  = mk(0, 0, 1, 0, 0, 32'h80,  32'h80,  1, 1, 0, 0);
    tbl[8]  = mk(0, 0, 1, 0, 0, 32'h20,  32'h20,  1, 1, 0, 0);
    tbl[9]  = mk(0, 0, 1, 1, 0, 32'h100, 32'h100, 1, 0, 0, 0); // call, push 0x24
    tbl[10] = mk(0, 0, 0, 0, 1, 32'h0,   32'h24,  1, 1, 0, 0); // return
    tbl[11] = mk(0, 0, 1, 0, 1, 32'h40,  32'h40,  1, 1, 0, 0); // ret under redirect ignored
    tbl[12] = mk(0, 0, 0, 1, 0, 32'h0,   32'h44,  1, 1, 0, 0); // call without redirect
    tbl[13] = mk(0, 1, 0, 0, 1, 32'h0,   32'h44,  1, 1, 0, 0); // stall beats ret
    tbl[14] = mk(0, 0, 1, 1, 0, 32'h200, 32'h200, 1, 0, 0, 0); // push 0x48
    tbl[15] = mk(0, 0, 1, 1, 0, 32'h300, 32'h300, 1, 0, 0, 0); // push 0x204
    tbl[16] = mk(0, 0, 1, 1, 0, 32'h400, 32'h400, 1, 0, 0, 0); // push 0x304
    tbl[17] = mk(0, 0, 1, 1, 0, 32'h500, 32'h500, 1, 0, 1, 0); // push 0x404, full
    tbl[18] = mk(0, 0, 1, 1, 0, 32'h600, 32'h600, 1, 0, 1, 1); // push 0x504 overwrites 0x48
    tbl[19] = mk(0, 0, 0, 0, 1, 32'h0,   32'h504, 1, 0, 0, 1);
    tbl[20] = mk(0, 0, 0, 0, 1, 32'h0,   32'h404, 1, 0, 0, 1);
    tbl[21] = mk(0, 0, 0, 0, 1, 32'h0,   32'h304, 1, 0, 0, 1);
    tbl[22] = mk(0, 0, 0, 0, 1, 32'h0,   32'h204, 1, 1, 0, 1);
    tbl[23] = mk(0, 0, 0, 0, 1, 32'h0,   32'h208, 1, 1, 0, 1); // underflow -> sequential
    tbl[24] = mk(0, 0, 0, 0, 0, 32'h0,   32'h20C, 1, 1, 0, 1);
    tbl[25] = mk(1, 0, 0, 0, 0, 32'h0,   32'h210, 1, 1, 0, 1); // start ignored in RUN

    rst = 1'b1;
    {start, hd, redir, call, ret} = '0;
    target = '0;
    start8 = 1'b0; redir8 = 1'b0; target8 = '0;
    #12;
    check_all("reset", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < NVec; i++) begin
      start = tbl[i].start; hd = tbl[i].hd; redir = tbl[i].redir;
      call = tbl[i].call; ret = tbl[i].ret; target = tbl[i].target;
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].valid, tbl[i].empty,
                tbl[i].full, tbl[i].err);
    end
    {start, hd, redir, call, ret} = '0;

    // Asynchronous reset between edges, held together with start.
    #1;
    rst = 1'b1;
    start = 1'b1;
    #1;
    check_all("async_rst", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("rst_with_start", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_all("restart", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    ret = 1'b1;
    tick();
    check_all("underflow", 32'h4, 1'b1, 1'b1, 1'b0, 1'b1);
    ret = 1'b0;
    tick();
    check_all("err_sticky", 32'h8, 1'b1, 1'b1, 1'b0, 1'b1);

    // 8-bit wraparound.
    check("w8 idle valid", 32'(valid8), 32'h0);
    start8 = 1'b1;
    tick();
    check("w8 start pc", 32'(pc8), 32'h0);
    start8 = 1'b0;
    redir8 = 1'b1;
    target8 = 8'hF8;
    tick();
    check("w8 redirect pc", 32'(pc8), 32'hF8);
    redir8 = 1'b0;
    tick();
    check("w8 pc FC", 32'(pc8), 32'hFC);
    check("w8 pc_seq wrap", 32'(pc_seq8), 32'h00);
    tick();
    check("w8 pc wrap", 32'(pc8), 32'h00);
    check("w8 valid", 32'(valid8), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
